// File: rtl/bomb_pkg.sv
// Shared tile codes, ray directions and controller states for the blast engine.
package bomb_pkg;

   localparam logic [7:0] TILE_WALL = 8'h00;
   localparam logic [7:0] TILE_PATH = 8'h80;
   localparam logic [7:0] TILE_WOOD = 8'h10;
   localparam logic [7:0] TILE_BOMB = 8'h20;
   localparam logic [7:0] TILE_EXPL = 8'h40;

   typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

   typedef enum logic [3:0] {
      IDLE, RAY_RD, RAY_EVAL, CENTER, HOLD, CLR_RD, CLR_EVAL, CLR_CENTER, DONE
   } bp_state_t;

endpackage

// File: rtl/blast_painter_if.sv
// Request, tile-map RAM and status bundle of the blast engine.
interface blast_painter_if #(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 4,
   parameter int LEN_BITS = 2
);
   logic                         req_valid;
   logic                         req_ready;
   logic [ROW_BITS-1:0]          req_row;
   logic [COL_BITS-1:0]          req_col;
   logic [LEN_BITS-1:0]          req_len;
   logic [ROW_BITS+COL_BITS-1:0] mem_addr;
   logic [7:0]                   mem_rdata;
   logic                         mem_we;
   logic [7:0]                   mem_wdata;
   logic                         busy;
   logic                         done;
   logic                         chain_valid;
   logic [ROW_BITS-1:0]          chain_row;
   logic [COL_BITS-1:0]          chain_col;

   modport slave (
      input  req_valid, req_row, req_col, req_len, mem_rdata,
      output req_ready, mem_addr, mem_we, mem_wdata, busy, done,
             chain_valid, chain_row, chain_col
   );

   modport master (
      output req_valid, req_row, req_col, req_len, mem_rdata,
      input  req_ready, mem_addr, mem_we, mem_wdata, busy, done,
             chain_valid, chain_row, chain_col
   );
endinterface

// File: rtl/blast_addr_step.sv
// One-tile step of a map address in a given direction; never wraps, flags the map edge instead.
module blast_addr_step
   import bomb_pkg::*;
#(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 4
) (
   input  logic [ROW_BITS+COL_BITS-1:0] addr,
   input  dir_t                         dir,
   output logic [ROW_BITS+COL_BITS-1:0] nbr,
   output logic                         at_edge
);
   logic [ROW_BITS-1:0] row;
   logic [COL_BITS-1:0] col;

   assign row = addr[ROW_BITS+COL_BITS-1:COL_BITS];
   assign col = addr[COL_BITS-1:0];

   always_comb begin
      at_edge = 1'b0;
      nbr     = addr;
      case (dir)
         UP: begin
            at_edge = (row == '0);
            if (!at_edge) nbr = {row - ROW_BITS'(1), col};
         end
         DOWN: begin
            at_edge = (row == '1);
            if (!at_edge) nbr = {row + ROW_BITS'(1), col};
         end
         LEFT: begin
            at_edge = (col == '0);
            if (!at_edge) nbr = {row, col - COL_BITS'(1)};
         end
         RIGHT: begin
            at_edge = (col == '1);
            if (!at_edge) nbr = {row, col + COL_BITS'(1)};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/blast_painter.sv
// Bomb-blast engine: paints EXPLOSION along four clipped rays, holds, then restores
// exactly the painted tiles to PATH.
module blast_painter
   import bomb_pkg::*;
#(
   parameter int ROW_BITS    = 4,
   parameter int COL_BITS    = 4,
   parameter int LEN_BITS    = 2,
   parameter int HOLD_CYCLES = 1024
) (
   input logic            clk,
   input logic            reset,
   blast_painter_if.slave bus
);
   localparam int AW = ROW_BITS + COL_BITS;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   bp_state_t                 state_q, state_d;
   dir_t                      dir_q, dir_d;
   logic [LEN_BITS-1:0]       step_q, step_d, len_q, len_d;
   logic [3:0][LEN_BITS-1:0]  reach_q, reach_d;
   logic [AW-1:0]             bomb_q, bomb_d, cur_q, cur_d;
   logic                      term_q, term_d;
   logic [HW-1:0]             hold_q, hold_d;
   logic                      ready_q, ready_d;
   logic [AW-1:0]             addr_q, addr_d;
   logic                      we_q, we_d;
   logic [7:0]                wdata_q, wdata_d;
   logic                      chain_v_q, chain_v_d;
   logic [AW-1:0]             chain_addr_q, chain_addr_d;
   logic [AW-1:0]             nbr;
   logic                      at_edge;

   blast_addr_step #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)) u_step (
      .addr    (cur_q),
      .dir     (dir_q),
      .nbr     (nbr),
      .at_edge (at_edge)
   );

   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      step_d       = step_q;
      len_d        = len_q;
      reach_d      = reach_q;
      bomb_d       = bomb_q;
      cur_d        = cur_q;
      term_d       = term_q;
      hold_d       = hold_q;
      addr_d       = addr_q;
      we_d         = 1'b0;
      wdata_d      = wdata_q;
      chain_v_d    = 1'b0;
      chain_addr_d = chain_addr_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid && ready_q) begin
               bomb_d  = {bus.req_row, bus.req_col};
               cur_d   = {bus.req_row, bus.req_col};
               len_d   = bus.req_len;
               dir_d   = UP;
               step_d  = '0;
               term_d  = 1'b0;
               state_d = RAY_RD;
            end
         end
         RAY_RD: begin
            // A ray ends on its length limit, the map edge, or a blocking tile seen last cycle.
            if (step_q == len_q || at_edge || term_q) begin
               reach_d[dir_q] = step_q;
               step_d         = '0;
               term_d         = 1'b0;
               cur_d          = bomb_q;
               if (dir_q != RIGHT) dir_d = dir_t'(dir_q + 2'd1);
               else                state_d = CENTER;
            end else begin
               addr_d  = nbr;
               cur_d   = nbr;
               state_d = RAY_EVAL;
            end
         end
         RAY_EVAL: begin
            state_d = RAY_RD;
            case (bus.mem_rdata)
               TILE_PATH, TILE_EXPL: begin
                  we_d    = 1'b1;
                  wdata_d = TILE_EXPL;
                  step_d  = step_q + LEN_BITS'(1);
               end
               TILE_WOOD: begin
                  we_d    = 1'b1;
                  wdata_d = TILE_EXPL;
                  step_d  = step_q + LEN_BITS'(1);
                  term_d  = 1'b1;
               end
               TILE_BOMB: begin
                  term_d       = 1'b1;
                  chain_v_d    = 1'b1;
                  chain_addr_d = cur_q;
               end
               default: term_d = 1'b1;
            endcase
         end
         CENTER: begin
            addr_d  = bomb_q;
            we_d    = 1'b1;
            wdata_d = TILE_EXPL;
            hold_d  = HW'(HOLD_CYCLES - 1);
            state_d = HOLD;
         end
         HOLD: begin
            if (hold_q == '0) begin
               dir_d   = UP;
               step_d  = '0;
               cur_d   = bomb_q;
               state_d = CLR_RD;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         CLR_RD: begin
            if (step_q == reach_q[dir_q]) begin
               step_d = '0;
               cur_d  = bomb_q;
               if (dir_q != RIGHT) dir_d = dir_t'(dir_q + 2'd1);
               else                state_d = CLR_CENTER;
            end else begin
               addr_d  = nbr;
               cur_d   = nbr;
               state_d = CLR_EVAL;
            end
         end
         CLR_EVAL: begin
            // Tiles changed by someone else during the hold are left alone.
            if (bus.mem_rdata == TILE_EXPL) begin
               we_d    = 1'b1;
               wdata_d = TILE_PATH;
            end
            step_d  = step_q + LEN_BITS'(1);
            state_d = CLR_RD;
         end
         CLR_CENTER: begin
            addr_d  = bomb_q;
            we_d    = 1'b1;
            wdata_d = TILE_PATH;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         dir_q        <= UP;
         step_q       <= '0;
         len_q        <= '0;
         reach_q      <= '0;
         bomb_q       <= '0;
         cur_q        <= '0;
         term_q       <= 1'b0;
         hold_q       <= '0;
         ready_q      <= 1'b0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         chain_v_q    <= 1'b0;
         chain_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         step_q       <= step_d;
         len_q        <= len_d;
         reach_q      <= reach_d;
         bomb_q       <= bomb_d;
         cur_q        <= cur_d;
         term_q       <= term_d;
         hold_q       <= hold_d;
         ready_q      <= ready_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         chain_v_q    <= chain_v_d;
         chain_addr_q <= chain_addr_d;
      end
   end

   assign bus.req_ready   = ready_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = (state_q == DONE);
   assign bus.mem_addr    = addr_q;
   assign bus.mem_we      = we_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.chain_valid = chain_v_q;
   assign bus.chain_row   = chain_addr_q[AW-1:COL_BITS];
   assign bus.chain_col   = chain_addr_q[COL_BITS-1:0];
endmodule

// File: tb/tb_blast_painter.sv
// Directed bench for blast_painter on a 16x16 map with an 8-cycle hold.
module tb_blast_painter;
   import bomb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   blast_painter_if #(.ROW_BITS(4), .COL_BITS(4), .LEN_BITS(2)) bus ();

   blast_painter #(.ROW_BITS(4), .COL_BITS(4), .LEN_BITS(2), .HOLD_CYCLES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Tile map: combinational read of the registered address, single writer process.
   logic [7:0] mem [256];
   logic       tb_fill, tb_wr_en;
   logic [7:0] tb_wr_addr, tb_wr_data;

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (tb_fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= TILE_PATH;
      end else if (tb_wr_en) begin
         mem[tb_wr_addr] <= tb_wr_data;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int count_code(input logic [7:0] code);
      int c = 0;
      for (int i = 0; i < 256; i++) if (mem[i] == code) c++;
      return c;
   endfunction

   task automatic fill_map();
      @(negedge clk); tb_fill = 1'b1;
      @(negedge clk); tb_fill = 1'b0;
   endtask

   task automatic set_tile(input int a, input int code);
      @(negedge clk);
      tb_wr_en = 1'b1; tb_wr_addr = 8'(a); tb_wr_data = 8'(code);
      @(negedge clk);
      tb_wr_en = 1'b0;
   endtask

   // p: paint cycles excluding CENTER; k: accept-to-done cycles; paint: EXPLOSION tiles at hold;
   // total: writes over the whole blast; never: address that must not be written.
   typedef struct {
      int row, col, len;
      int ob0, c0, ob1, c1;
      int p, k, paint, total;
      int chains, chain_at, final_path;
      int never, corrupt, first_wr;
   } vec_t;

   vec_t vecs [9];

   task automatic run_vec(input int vi);
      vec_t v;
      int   n, wr, chains, never_hits, last_chain;
      bit   got;
      v = vecs[vi];
      fill_map();
      if (v.ob0 >= 0) set_tile(v.ob0, v.c0);
      if (v.ob1 >= 0) set_tile(v.ob1, v.c1);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_row   = 4'(v.row);
      bus.req_col   = 4'(v.col);
      bus.req_len   = 2'(v.len);
      check("ready_before_accept", int'(bus.req_ready), 1);
      @(posedge clk);
      n = 0; wr = 0; chains = 0; never_hits = 0; last_chain = -1; got = 1'b0;
      while (!got && n < 500) begin
         @(negedge clk);
         n++;
         bus.req_valid = 1'b0;
         tb_wr_en      = 1'b0;
         if (n == 1) check("busy_after_accept", int'(bus.busy), 1);
         if (n == 3 && v.first_wr >= 0) begin
            check("first_write_we", int'(bus.mem_we), 1);
            check("first_write_addr", int'(bus.mem_addr), v.first_wr);
         end
         if (bus.mem_we) begin
            wr++;
            if (int'(bus.mem_addr) == v.never) never_hits++;
         end
         if (bus.chain_valid) begin
            chains++;
            last_chain = int'({bus.chain_row, bus.chain_col});
         end
         if (n == v.p + 5) begin
            check("explosion_tiles_in_hold", count_code(TILE_EXPL), v.paint);
            if (v.corrupt >= 0) begin
               tb_wr_en = 1'b1; tb_wr_addr = 8'(v.corrupt); tb_wr_data = TILE_WOOD;
            end
         end
         if (bus.done) got = 1'b1;
      end
      check("done_seen", int'(got), 1);
      check("accept_to_done_cycles", n, v.k);
      check("total_writes", wr, v.total);
      check("chain_pulses", chains, v.chains);
      if (v.chains > 0) check("chain_location", last_chain, v.chain_at);
      if (v.never >= 0) check("forbidden_addr_writes", never_hits, 0);
      @(negedge clk);
      check("done_single_pulse", int'(bus.done), 0);
      check("final_path_tiles", count_code(TILE_PATH), v.final_path);
      $display("[TB] vec %0d bomb(%0d,%0d) len %0d: %0d cycles, %0d writes, %0d chains",
               vi, v.row, v.col, v.len, n, wr, chains);
   endtask

   initial begin
      int  acc;
      bit  got;
      int  wr;

      vecs[0] = '{5, 5, 2,  -1, 0, -1, 0,  20, 51, 9, 18,  0, -1, 256,  -1, -1, 'h45};
      vecs[1] = '{0, 0, 3,  -1, 0, -1, 0,  16, 43, 7, 14,  0, -1, 256,  'hF0, -1, -1};
      vecs[2] = '{5, 5, 3,  'h56, 'h10, 'h35, 'h00,  22, 53, 9, 18,  0, -1, 255,  'h57, -1, -1};
      vecs[3] = '{5, 5, 3,  'h75, 'h20, -1, 0,  26, 61, 11, 22,  1, 'h75, 255,  -1, -1, -1};
      vecs[4] = '{15, 15, 3,  -1, 0, -1, 0,  16, 43, 7, 14,  0, -1, 256,  'h0F, -1, -1};
      vecs[5] = '{5, 5, 0,  -1, 0, -1, 0,  4, 19, 1, 2,  0, -1, 256,  -1, -1, -1};
      vecs[6] = '{1, 14, 3,  -1, 0, -1, 0,  20, 51, 9, 18,  0, -1, 256,  'h10, -1, -1};
      vecs[7] = '{5, 5, 2,  'h54, 'h55, 'h65, 'h40,  18, 45, 7, 14,  0, -1, 255,  -1, -1, -1};
      vecs[8] = '{5, 5, 2,  -1, 0, -1, 0,  20, 51, 9, 17,  0, -1, 255,  -1, 'h45, -1};

      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_row = '0; bus.req_col = '0; bus.req_len = '0;
      tb_fill = 1'b0; tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
      #1;
      check("reset_ready", int'(bus.req_ready), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_mem_we", int'(bus.mem_we), 0);
      check("reset_mem_addr", int'(bus.mem_addr), 0);
      check("reset_chain", int'({bus.chain_valid, bus.chain_row, bus.chain_col}), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_release", int'(bus.req_ready), 1);

      for (int i = 0; i < 9; i++) run_vec(i);

      // Request held high across a whole blast: only one accept until the cycle after done.
      fill_map();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_row = 4'd5; bus.req_col = 4'd5; bus.req_len = 2'd2;
      acc = 0; got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         if (bus.req_valid && bus.req_ready) acc++;
         if (bus.done) got = 1'b1;
         else @(negedge clk);
      end
      check("held_req_done", int'(got), 1);
      check("held_req_accepts", acc, 1);
      @(negedge clk);
      check("ready_cycle_after_done", int'(bus.req_ready), 1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("second_accept_busy", int'(bus.busy), 1);
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         if (bus.done) got = 1'b1;
      end
      check("second_blast_done", int'(got), 1);
      $display("[TB] held request: %0d accept(s) before done", acc);

      // Reset in the middle of HOLD.
      fill_map();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_row = 4'd5; bus.req_col = 4'd5; bus.req_len = 2'd2;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (24) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_busy", int'(bus.busy), 0);
      check("midreset_ready", int'(bus.req_ready), 0);
      check("midreset_mem_we", int'(bus.mem_we), 0);
      check("midreset_mem_addr", int'(bus.mem_addr), 0);
      wr = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.mem_we || bus.done) wr++;
      end
      check("midreset_activity", wr, 0);
      check("midreset_tiles_left", count_code(TILE_EXPL), 9);
      reset = 1'b0;
      @(negedge clk);
      check("midreset_ready_release", int'(bus.req_ready), 1);
      $display("[TB] reset during hold: %0d explosion tiles left", count_code(TILE_EXPL));
      run_vec(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule
